// File: rtl/regfile_mp.sv
// regfile_mp: register file with two write ports, NUM_READ combinational
// read ports, an optional hardwired-zero entry 0, optional write-to-read
// bypass and a built-in clear sequencer.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   clear_req       start a clear sequence (honoured only in IDLE)
//   we1/wa1/wd1     write port 1
//   we2/wa2/wd2     write port 2 (wins on same-address conflict)
//   ra / rd         packed read addresses / read data, lane k at k*WIDTH
//   busy            high while the clear sequencer is running
module regfile_mp #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear_req,
    input  logic                           we1,
    input  logic [ADDR_WIDTH-1:0]          wa1,
    input  logic [DATA_WIDTH-1:0]          wd1,
    input  logic                           we2,
    input  logic [ADDR_WIDTH-1:0]          wa2,
    input  logic [DATA_WIDTH-1:0]          wd2,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] ra,
    output logic [NUM_READ*DATA_WIDTH-1:0] rd,
    output logic                           busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic wr_ok;
    logic we1_ok;
    logic we2_ok;

    assign busy  = (state_q == ST_CLEAR);
    assign wr_ok = !rst && (state_q == ST_IDLE);

    // Writes to entry 0 are dropped when it is hardwired to zero.
    assign we1_ok = wr_ok && we1 && !(ZERO_REG != 0 && wa1 == '0);
    assign we2_ok = wr_ok && we2 && !(ZERO_REG != 0 && wa2 == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                // cnt wraps back to 0 on the last entry.
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Port 2 is assigned last so it overrides port 1 on equal addresses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_CLEAR) begin
                mem_q[cnt_q] <= '0;
            end else begin
                if (we1_ok) begin
                    mem_q[wa1] <= wd1;
                end
                if (we2_ok) begin
                    mem_q[wa2] <= wd2;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;

        assign addr = ra[k*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            data = mem_q[addr];
            if (busy) begin
                data = '0;
            end else if (ZERO_REG != 0 && addr == '0) begin
                data = '0;
            end else if (BYPASS != 0 && wr_ok && we2 && wa2 == addr) begin
                data = wd2;
            end else if (BYPASS != 0 && wr_ok && we1 && wa1 == addr) begin
                data = wd1;
            end
        end

        assign rd[k*DATA_WIDTH +: DATA_WIDTH] = data;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file: two write ports, `NUM_READ` combinational read ports, optional hardwired-zero register 0 and optional write-to-read bypass. A built-in clear sequencer zeroes every entry after reset or on request, one entry per cycle. It sits in the datapath as the general-purpose register store and replaces the fixed 1-write/2-read file.

## Interface

Parameters:

- `ADDR_WIDTH`, 4, address width; depth is `2**ADDR_WIDTH`.
- `DATA_WIDTH`, 8, register width.
- `NUM_READ`, 2, number of read ports; must be ≥1.
- `ZERO_REG`, 1, when 1 entry 0 always reads 0 and ignores writes.
- `BYPASS`, 1, when 1 a read of an address written this cycle returns the write data.

Ports:

- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `clear_req` input 1: start a clear sequence; sampled only in IDLE.
- `we1` input 1: write enable, port 1.
- `wa1` input `ADDR_WIDTH`: write address, port 1.
- `wd1` input `DATA_WIDTH`: write data, port 1.
- `we2` input 1: write enable, port 2.
- `wa2` input `ADDR_WIDTH`: write address, port 2.
- `wd2` input `DATA_WIDTH`: write data, port 2.
- `ra` input `NUM_READ*ADDR_WIDTH`: packed read addresses; port k uses bits `[k*ADDR_WIDTH +: ADDR_WIDTH]`.
- `rd` output `NUM_READ*DATA_WIDTH`: packed read data, same packing as `ra`.
- `busy` output 1: high while the clear sequence runs.

## Operation

- FSM states: IDLE and CLEAR. Clear counter `cnt` is `ADDR_WIDTH` bits wide.
- `rst` high at an edge: next state CLEAR and `cnt` = 0. This applies from any state, including mid-clear, which restarts the sequence at entry 0.
- CLEAR state:
  - Each edge writes 0 to `mem[cnt]` and increments `cnt`.
  - The edge that writes entry `2**ADDR_WIDTH-1` moves the FSM to IDLE; `cnt` wraps to 0.
- IDLE with `clear_req` high: next state CLEAR, `cnt` = 0. `clear_req` is ignored in CLEAR.
- Writes:
  - Applied only in IDLE with `rst` low. `we1`/`we2` are ignored in CLEAR and during `rst`.
  - Both enabled at the same address: port 2 wins; port 1's write is dropped.
  - Different addresses: both written on the same edge.
  - `ZERO_REG`=1: writes to address 0 are discarded.
- Reads (combinational, per port, in priority order):
  1. `busy`=1 → 0.
  2. `ZERO_REG`=1 and address 0 → 0.
  3. `BYPASS`=1 and `we2` and `wa2`==addr → `wd2`.
  4. `BYPASS`=1 and `we1` and `wa1`==addr → `wd1`.
  5. Otherwise → `mem[addr]`.
- Bypass applies only when the write itself would be accepted (IDLE, `rst` low).
- All read ports are independent; several ports may read the same address.

## Timing

- Read latency: 0 cycles (combinational from `ra`, write inputs and state).
- Write latency: data is visible at `rd` from the cycle after the write edge. With `BYPASS`=1 it is also visible in the write cycle itself.
- Clear duration: exactly `2**ADDR_WIDTH` cycles with `busy`=1 after the `rst` or `clear_req` edge, counting from the cycle after that edge. Holding `rst` high extends the duration; `cnt` is held at 0 while `rst` is high.
- Reset values:
  - `busy`=1 from the first `rst` edge.
  - All `rd` lanes read 0 from the first `rst` edge.
  - After the clear completes, every entry is 0.
- Before the first `rst`, memory and FSM contents are undefined.
- `busy` is driven directly from the state register; no combinational path from inputs.

## Test plan

- **Reset and clear:** pulse `rst` for 1 cycle (ADDR_WIDTH=4) → `busy` high for exactly 16 cycles; every read lane returns 0 during and after the clear.
- **Basic write/read:** in IDLE, write 0xA5 to entry 3 via port 1; read entry 3 next cycle → 0xA5. With `BYPASS`=1, a read of entry 3 in the write cycle → 0xA5. With `BYPASS`=0 → old value 0x00.
- **Same-address write conflict:** `we1`/`we2` to entry 5 with 0x11/0x22 → entry 5 = 0x22 next cycle. Bypass read of 5 in the write cycle → 0x22.
- **Hardwired zero:** `ZERO_REG`=1, write 0xFF to entry 0 → reads of entry 0 stay 0x00, including in the bypass cycle. `ZERO_REG`=0 → reads 0xFF.
- **Runtime clear with blocked writes:** fill entries 1–15, then pulse `clear_req`. Issue writes during `busy` → writes ignored and `rd`=0. After 16 cycles all entries read 0.
- **Reset mid-clear:** assert `rst` at cycle 7 of a clear → `busy` stays high for 16 further cycles; entries 0–15 all read 0 afterwards.
